// File: rtl/ahb_lite_master.sv
// Single-transfer AHB-Lite master: takes one command at a time and runs a NONSEQ
// transfer. Handles wait states, two-cycle ERROR responses and a data-phase timeout.
module ahb_lite_master #(
  parameter int unsigned TIMEOUT = 16,
  parameter logic [3:0]  PROT    = 4'b0011
) (
  input  logic        HMASTCLOCK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [2:0]  cmd_size,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] HADDR,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [1:0]  HTRANS,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StErr2} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic [31:0] wdata_q, wdata_d;
  logic        ready_d, valid_d, err_d, tmo_d, hwrite_d;
  logic [31:0] rdata_d, haddr_d, hwdata_d;
  logic [2:0]  hsize_d;
  logic [1:0]  htrans_d;

  assign HBURST  = 3'b000;
  assign HPROT   = PROT;
  assign cnt_inc = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wdata_d  = wdata_q;
    ready_d  = 1'b0;
    valid_d  = 1'b0;
    rdata_d  = rsp_rdata;
    err_d    = rsp_err;
    tmo_d    = rsp_timeout;
    htrans_d = 2'b00;
    haddr_d  = HADDR;
    hwrite_d = HWRITE;
    hsize_d  = HSIZE;
    hwdata_d = HWDATA;
    unique case (state_q)
      StIdle: begin
        // cmd_ready is held low for the response cycle, so this also blocks re-accept there
        ready_d = 1'b1;
        if (cmd_valid && cmd_ready) begin
          state_d  = StAddr;
          ready_d  = 1'b0;
          htrans_d = 2'b10;
          haddr_d  = cmd_addr;
          hwrite_d = cmd_write;
          hsize_d  = cmd_size;
          wdata_d  = cmd_wdata;
        end
      end
      StAddr: begin
        if (HREADY) begin
          state_d  = StData;
          cnt_d    = 8'd0;
          hwdata_d = HWRITE ? wdata_q : 32'h0;
        end else begin
          htrans_d = 2'b10;
        end
      end
      StData, StErr2: begin
        if (HREADY) begin
          state_d = StIdle;
          valid_d = 1'b1;
          tmo_d   = 1'b0;
          if (state_q == StErr2 || HRESP) begin
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            err_d   = 1'b0;
            rdata_d = HWRITE ? 32'h0 : HRDATA;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TimeoutCnt) begin
            state_d = StIdle;
            valid_d = 1'b1;
            tmo_d   = 1'b1;
            err_d   = 1'b0;
            rdata_d = 32'h0;
          end else if (state_q == StData && HRESP) begin
            state_d = StErr2;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HMASTCLOCK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      wdata_q     <= 32'h0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'h0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      HTRANS      <= 2'b00;
      HADDR       <= 32'h0;
      HWRITE      <= 1'b0;
      HSIZE       <= 3'b000;
      HWDATA      <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      cmd_ready   <= ready_d;
      rsp_valid   <= valid_d;
      rsp_rdata   <= rdata_d;
      rsp_err     <= err_d;
      rsp_timeout <= tmo_d;
      HTRANS      <= htrans_d;
      HADDR       <= haddr_d;
      HWRITE      <= hwrite_d;
      HSIZE       <= hsize_d;
      HWDATA      <= hwdata_d;
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: scripted slave responses per transfer, expected outputs
// derived from the transfer's outcome, checked every cycle on the falling edge.
module tb_ahb_lite_master;

  localparam int TMO = 16;

  logic        HMASTCLOCK = 1'b0;
  logic        HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;

  ahb_lite_master #(.TIMEOUT(TMO), .PROT(4'b0011)) dut (
    .HMASTCLOCK(HMASTCLOCK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HTRANS(HTRANS), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 HMASTCLOCK = ~HMASTCLOCK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rsp_cyc = 0;

  // expected outputs for the current cycle
  logic        chk_en = 1'b0;
  logic        exp_ready, exp_valid, exp_err, exp_tmo, exp_write;
  logic        chk_addr, chk_wdata;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;
  logic [2:0]  exp_size;
  logic [1:0]  exp_trans;
  logic        last_err, last_tmo;
  logic [31:0] last_rdata;

  // slave script for the data phase of one transfer
  logic        s_hr [16];
  logic        s_hp [16];
  logic [31:0] s_rd [16];

  always @(posedge HMASTCLOCK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge HMASTCLOCK) begin
    if (chk_en) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_tmo));
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("HTRANS", 32'(HTRANS), 32'(exp_trans));
      chk("HPROT", 32'(HPROT), 32'h3);
      chk("HBURST", 32'(HBURST), 32'h0);
      if (chk_addr) begin
        chk("HADDR", HADDR, exp_addr);
        chk("HWRITE", 32'(HWRITE), 32'(exp_write));
        chk("HSIZE", 32'(HSIZE), 32'(exp_size));
      end
      if (chk_wdata) chk("HWDATA", HWDATA, exp_wdata);
      if (rsp_valid) rsp_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge HMASTCLOCK);
    #1;
  endtask

  // commands shown while busy must be ignored
  task automatic garbage();
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_size  = 3'($urandom_range(0, 2));
  endtask

  task automatic set_idle_exp();
    exp_ready = 1'b1;
    exp_valid = 1'b0;
    exp_trans = 2'b00;
    chk_addr  = 1'b0;
    chk_wdata = 1'b0;
    exp_rdata = last_rdata;
    exp_err   = last_err;
    exp_tmo   = last_tmo;
  endtask

  task automatic set_reset_exp();
    last_rdata = 32'h0;
    last_err   = 1'b0;
    last_tmo   = 1'b0;
    set_idle_exp();
    chk_addr  = 1'b1;
    exp_addr  = 32'h0;
    exp_write = 1'b0;
    exp_size  = 3'b000;
    chk_wdata = 1'b1;
    exp_wdata = 32'h0;
  endtask

  task automatic idle();
    step();
    cmd_valid = 1'b0;
    HREADY    = 1'($urandom_range(0, 1));
    HRESP     = 1'b0;
    HRDATA    = $urandom;
    set_idle_exp();
  endtask

  // One command: aw address-phase wait cycles, then the data phase follows s_hr/s_hp/s_rd.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] size, input int aw);
    int   end_d, waits, kind;  // kind: 0 okay, 1 error, 2 timeout
    logic errf;
    end_d = 15;
    waits = 0;
    kind  = 2;
    errf  = 1'b0;
    for (int d = 0; d < 16; d++) begin
      if (s_hr[d]) begin
        end_d = d;
        kind  = (errf || s_hp[d]) ? 1 : 0;
        break;
      end
      waits++;
      if (s_hp[d]) errf = 1'b1;
      if (waits == TMO) begin
        end_d = d;
        kind  = 2;
        break;
      end
    end

    step();
    HRESET    = 1'b0;
    chk_en    = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_size  = size;
    HREADY    = 1'($urandom_range(0, 1));
    HRESP     = 1'b0;
    HRDATA    = $urandom;
    set_idle_exp();
    acc_cyc = cyc;

    for (int a = 0; a <= aw; a++) begin
      step();
      garbage();
      HREADY    = (a == aw);
      HRESP     = 1'b0;
      HRDATA    = $urandom;
      exp_ready = 1'b0;
      exp_trans = 2'b10;
      chk_addr  = 1'b1;
      exp_addr  = addr;
      exp_write = wr;
      exp_size  = size;
      chk_wdata = 1'b0;
    end

    for (int d = 0; d <= end_d; d++) begin
      step();
      garbage();
      HREADY    = s_hr[d];
      HRESP     = s_hp[d];
      HRDATA    = s_rd[d];
      exp_trans = 2'b00;
      chk_wdata = wr;
      exp_wdata = wdata;
    end

    step();
    garbage();
    HREADY     = 1'($urandom_range(0, 1));
    HRESP      = 1'b0;
    HRDATA     = $urandom;
    last_err   = (kind == 1);
    last_tmo   = (kind == 2);
    last_rdata = (kind == 0 && !wr) ? s_rd[end_d] : 32'h0;
    exp_valid  = 1'b1;
    exp_ready  = 1'b0;
    exp_trans  = 2'b00;
    chk_addr   = 1'b0;
    chk_wdata  = 1'b0;
    exp_rdata  = last_rdata;
    exp_err    = last_err;
    exp_tmo    = last_tmo;
  endtask

  task automatic script_fill(input logic hr, input logic hp);
    for (int d = 0; d < 16; d++) begin
      s_hr[d] = hr;
      s_hp[d] = hp;
      s_rd[d] = $urandom;
    end
  endtask

  initial begin
    HRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    cmd_size  = 3'b000;
    HREADY    = 1'b0;
    HRESP     = 1'b0;
    HRDATA    = 32'h0;
    set_reset_exp();
    #1 chk_en = 1'b1;
    step();
    step();
    chk("reset_hprot", 32'(HPROT), 32'h3);
    chk("reset_ready", 32'(cmd_ready), 32'h1);

    // single-cycle read
    script_fill(1'b1, 1'b0);
    s_rd[0] = 32'h1000_0000;
    run_txn(1'b0, 32'h0000_0040, 32'h0, 3'd2, 0);
    idle();
    chk("read_latency", 32'(rsp_cyc - acc_cyc), 32'd3);
    chk("read_rdata", rsp_rdata, 32'h1000_0000);
    chk("read_err", 32'(rsp_err), 32'h0);

    // write with three wait states
    script_fill(1'b0, 1'b0);
    s_hr[3] = 1'b1;
    run_txn(1'b1, 32'h0000_0080, 32'hDEAD_BEEF, 3'd2, 0);
    idle();
    chk("write_latency", 32'(rsp_cyc - acc_cyc), 32'd6);
    chk("write_err", 32'(rsp_err), 32'h0);
    chk("write_rdata", rsp_rdata, 32'h0);

    // two-cycle error response
    script_fill(1'b0, 1'b1);
    s_hr[1] = 1'b1;
    run_txn(1'b0, 32'h0000_0100, 32'h0, 3'd2, 0);
    idle();
    chk("error_latency", 32'(rsp_cyc - acc_cyc), 32'd4);
    chk("error_err", 32'(rsp_err), 32'h1);
    chk("error_rdata", rsp_rdata, 32'h0);

    // slave never ready
    script_fill(1'b0, 1'b0);
    run_txn(1'b0, 32'h0000_0200, 32'h0, 3'd1, 1);
    idle();
    chk("timeout_latency", 32'(rsp_cyc - acc_cyc), 32'd19);
    chk("timeout_flag", 32'(rsp_timeout), 32'h1);
    chk("timeout_ready_after", 32'(cmd_ready), 32'h1);

    // reset in the data phase of a write
    step();
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h0000_0080;
    cmd_wdata = 32'h1234_5678;
    cmd_size  = 3'd2;
    set_idle_exp();
    step();
    garbage();
    HREADY    = 1'b1;
    exp_ready = 1'b0;
    exp_trans = 2'b10;
    step();
    HREADY    = 1'b0;
    #2;
    chk_en = 1'b0;
    HRESET = 1'b1;
    #1;
    chk("rst_async_ready", 32'(cmd_ready), 32'h1);
    chk("rst_async_valid", 32'(rsp_valid), 32'h0);
    chk("rst_async_haddr", HADDR, 32'h0);
    chk("rst_async_hwdata", HWDATA, 32'h0);
    chk("rst_async_hwrite", 32'(HWRITE), 32'h0);
    chk("rst_async_timeout", 32'(rsp_timeout), 32'h0);
    set_reset_exp();
    chk_en = 1'b1;
    step();
    cmd_valid = 1'b0;
    script_fill(1'b1, 1'b0);
    s_rd[0] = 32'hCAFE_0001;
    run_txn(1'b0, 32'h0000_0044, 32'h0, 3'd2, 0);
    idle();
    chk("post_reset_rdata", rsp_rdata, 32'hCAFE_0001);

    // randomized traffic
    for (int t = 0; t < 80; t++) begin
      int   gaps, aw;
      logic tmo;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) idle();
      aw  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      tmo = ($urandom_range(0, 9) == 0);
      for (int d = 0; d < 16; d++) begin
        s_hr[d] = tmo ? 1'b0 : ($urandom_range(0, 2) != 0);
        s_hp[d] = ($urandom_range(0, 5) == 0);
        s_rd[d] = $urandom;
      end
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 2)), aw);
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master.md
AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 Parameter TIMEOUT, default 16: max data-phase wait cycles with HREADY low before abort; legal 2..255.
REQ-002 Parameter PROT, default 4'b0011: constant HPROT value (data, privileged).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 HMASTCLOCK  in  1  bus clock; all state changes on its rising edge.
REQ-005 HRESET  in  1  asynchronous, active-high reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  32  transfer address.
REQ-010 cmd_wdata  in  32  write data.
REQ-011 cmd_size  in  3  HSIZE code; legal 0..2.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  32  read data, valid with rsp_valid.
REQ-014 rsp_err  out  1  slave returned ERROR, valid with rsp_valid.
REQ-015 rsp_timeout  out  1  transfer aborted by timeout, valid with rsp_valid.
REQ-016 HADDR, HWDATA  out  32 each; HWRITE  out  1; HSIZE, HBURST  out  3 each; HPROT  out  4; HTRANS  out  2.
REQ-017 HREADY  in  1; HRESP  in  1; HRDATA  in  32.

Function
REQ-018 FSM states: IDLE, ADDR, DATA, ERR2; registered outputs only.
REQ-019 IDLE: cmd_ready=1, HTRANS=2'b00; on accept, latch cmd_* fields, go ADDR next cycle.
REQ-020 ADDR: HTRANS=2'b10 (NONSEQ), HADDR/HWRITE/HSIZE from latched command, HBURST=3'b000, HPROT=PROT; cmd_ready=0.
REQ-021 ADDR: if HREADY=1 go DATA; if HREADY=0 hold ADDR with all address signals stable.
REQ-022 DATA: HTRANS=2'b00; HWDATA=latched wdata for writes, held stable until DATA exits; HADDR/HWRITE/HSIZE remain at latched values.
REQ-023 DATA, HREADY=1, HRESP=0: pulse rsp_valid, rsp_err=0, rsp_rdata=HRDATA (reads) or 0 (writes); go IDLE.
REQ-024 DATA, HREADY=0, HRESP=1 (first ERROR cycle): go ERR2, HTRANS stays IDLE.
REQ-025 ERR2: on HREADY=1 pulse rsp_valid with rsp_err=1, rsp_rdata=0; go IDLE; if HREADY=0 remain ERR2.
REQ-026 DATA, HREADY=1, HRESP=1 (protocol violation): treat as error completion, rsp_err=1.
REQ-027 Wait counter (8 bits) clears on entry to DATA, increments each DATA/ERR2 cycle with HREADY=0; saturates at 255.
REQ-028 Counter reaching TIMEOUT: pulse rsp_valid, rsp_timeout=1, rsp_err=0, rsp_rdata=0; go IDLE.
REQ-029 Completion and timeout in same cycle: completion wins, rsp_timeout=0.
REQ-030 cmd_ready SHALL be 1 only in IDLE; commands presented elsewhere are not accepted and must be held by source.
REQ-031 Minimum command-to-response latency: 3 cycles (accept, ADDR, DATA with HREADY=1); next accept earliest the cycle after rsp_valid.
REQ-032 rsp_rdata/rsp_err/rsp_timeout SHALL hold last values between pulses.

Reset
REQ-033 HRESET=1 asynchronously forces IDLE: cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_timeout=0, rsp_rdata=0, HTRANS=0, HADDR=0, HWDATA=0, HWRITE=0, HSIZE=0, HBURST=0, HPROT=PROT, counter=0.
REQ-034 Reset mid-transfer abandons it with no rsp_valid pulse; first accept allowed in first cycle after HRESET deasserts.

Verification
REQ-035 Read 0x0000_0040, size 2, slave HREADY=1, HRDATA=0x1000_0000 -> HTRANS=NONSEQ one cycle, rsp_valid 3 cycles after accept, rsp_rdata=0x1000_0000, rsp_err=0.
REQ-036 Write 0x0000_0080 data 0xDEAD_BEEF, slave HREADY low 3 cycles -> HWDATA=0xDEAD_BEEF stable all 4 data cycles, rsp_valid on 4th, rsp_err=0.
REQ-037 Read, slave returns HRESP=1/HREADY=0 then HRESP=1/HREADY=1 -> HTRANS=IDLE both cycles, single rsp_valid with rsp_err=1, rsp_rdata=0.
REQ-038 Read, HREADY held 0, TIMEOUT=16 -> rsp_valid with rsp_timeout=1 after 16 wait cycles, cmd_ready=1 next cycle.
REQ-039 HRESET asserted during DATA of a write -> outputs immediately at reset values, no rsp_valid; new read after release completes normally.
REQ-040 cmd_valid held during busy transfer -> no second accept until cycle after rsp_valid; back-to-back commands each yield exactly one rsp_valid.
